// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file debug dump engine.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read port plus the (idx, data) valid/ready stream to the trace link.
interface regfile_dump_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]    rf_raddr;
  logic [WIDTH-1:0] rf_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_idx;

  modport master (
    output rf_raddr,
    input  rf_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_idx
  );

  modport slave (
    input  rf_raddr,
    output rf_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_idx
  );
endinterface

// File: rtl/regfile_dump_addr_counter.sv
// Register address walker: clears at dump start, steps once per accepted word.
module addr_counter #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks every register through a dedicated read port and streams (idx, data) pairs out.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  regfile_dump_if.master bus,
  output logic           busy,
  output logic           done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  dump_state_t   state, nxt;
  logic          clr, inc, hs, last;
  logic [AW-1:0] cnt;

  addr_counter #(.AW(AW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc),
    .cnt (cnt)
  );

  assign hs   = bus.out_valid & bus.out_ready;
  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    clr = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr = 1'b1;
        nxt = READ;
      end
      READ: nxt = SEND;
      SEND: if (hs) begin
        // the counter parks on the last address rather than wrapping
        if (!last) begin
          inc = 1'b1;
          nxt = READ;
        end else begin
          nxt = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
    end else begin
      case (state)
        READ: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= bus.rf_rdata;
          bus.out_idx   <= cnt;
        end
        SEND: if (hs) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rf_raddr = cnt;
  assign busy         = (state == READ) || (state == SEND);
  assign done         = (state == DONE);

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug readout engine for the processor's register file. On a start pulse it walks every register address through a dedicated register-file read port, captures each value, and streams (index, data) pairs out over a valid/ready handshake to the debug/trace link. It sits beside the register file, owning one read port, and never writes architectural state.

## Interface
- WIDTH, 32, data width of one register
- NREGS, 32, number of registers walked (≥2)
- AW, $clog2(NREGS), register address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE
- rf_raddr  out  AW  read address to register file
- rf_rdata  in  WIDTH  register file read data, combinational from rf_raddr (same cycle)
- out_valid  out  1  out_data/out_idx hold a word
- out_ready  in  1  consumer accepts word when high with out_valid
- out_data  out  WIDTH  captured register value
- out_idx  out  AW  address the word came from
- busy  out  1  high in READ and SEND
- done  out  1  one-cycle pulse after last word accepted

## Operation
- One clock (`clk`); reset is synchronous and active-low (`rst` = 0 resets on the next rising edge).
- States: IDLE, READ, SEND, DONE.
- IDLE: start=1 → READ, address counter cleared to 0. start=0 → stay.
- READ: rf_raddr = counter; on the edge, out_data ← rf_rdata, out_idx ← counter, out_valid ← 1 → SEND.
- SEND: out_valid=1, out_data/out_idx stable until handshake (out_valid & out_ready).
  - Handshake and counter < NREGS-1: counter+1, out_valid ← 0 → READ.
  - Handshake and counter == NREGS-1: out_valid ← 0 → DONE. Counter does not wrap past NREGS-1.
- DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE ignored (no queueing, no restart).
- rf_raddr driven with the counter in all states; value is don't-care outside READ.
- Register file contents assumed stable during a dump; any change is reflected only for addresses not yet read.

## Timing
- Reset values: state IDLE, counter 0, rf_raddr 0, out_valid 0, out_data 0, out_idx 0, busy 0, done 0.
- start at cycle T → READ at T+1 → first out_valid at T+2.
- Per word: 1 READ cycle + ≥1 SEND cycle; peak rate 1 word / 2 cycles with out_ready held high.
- Full dump with out_ready=1: start at T, done high at cycle T+2·NREGS+1, IDLE at T+2·NREGS+2.
- Backpressure: out_ready low stalls indefinitely in SEND; no word lost or duplicated.
- out_ready high while out_valid low: no effect.
- Reset mid-dump (any state): next edge returns all outputs to reset values; no done pulse; out_valid drops without handshake.
- start coinciding with reset: reset wins.
- busy is registered-state decode, combinational from state only.

## Structure
- Shared package `regfile_dump_pkg`: state enum `dump_state_t` {IDLE, READ, SEND, DONE}.
- One sub-module `addr_counter`: AW-bit counter with sync active-low reset, clear, and increment enable; top holds FSM and output registers.

## Test plan
- Reset: hold rst=0 three cycles with start=1 → out_valid=0, busy=0, done=0, rf_raddr=0, state IDLE.
- Full dump, no backpressure: regfile model reg[i]=0x1000_0000+i, start at cycle 10, out_ready=1 → 32 words idx 0..31 data 0x1000_0000..0x1000_001F in order, first valid cycle 12, done pulse cycle 75 only.
- Backpressure: out_ready low for 5 cycles on idx 7 → out_valid held, out_data=0x1000_0007 stable, idx 8 appears only after acceptance; total words still 32, no duplicates.
- Start while busy: second start pulse at idx 3 → ignored; exactly one done pulse, 32 words.
- Reset mid-dump: rst=0 during SEND at idx 12 → next cycle out_valid=0, busy=0, no done; new start → dump restarts at idx 0.
- Back-to-back dumps: start on the cycle after done → second full 32-word sequence, idx restarts at 0.
